// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seg_pkg;

    typedef enum logic {BLANK, SHOW} state_e;

    // Segment patterns, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Non-decimal codes fall back to a dash rather than indexing past the table.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d < 4'd10) ? SEG_LUT[d] : SEG_DASH;
    endfunction

endpackage

// File: rtl/segment_scan_if.sv
// Display-side bundle of the segment scanner.
// With SEGMENT_SCAN_BLINK_EN defined the bundle also carries blink_mask.
interface segment_scan_if #(
    parameter int unsigned N_FIELDS = 2,
    parameter int unsigned FIELD_W  = 6
);
    localparam int unsigned N_DIGITS = 2 * N_FIELDS;

    logic                          enable;
    logic [N_FIELDS*FIELD_W-1:0]   data_show;
    logic [N_DIGITS-1:0]           bytee;
    logic [6:0]                    segment;
    logic                          frame_start;
`ifdef SEGMENT_SCAN_BLINK_EN
    logic [N_FIELDS-1:0]           blink_mask;

    modport master (output enable, data_show, blink_mask, input bytee, segment, frame_start);
    modport slave  (input enable, data_show, blink_mask, output bytee, segment, frame_start);
`else
    modport master (output enable, data_show, input bytee, segment, frame_start);
    modport slave  (input enable, data_show, output bytee, segment, frame_start);
`endif

endinterface

// File: rtl/seg_bin2dec.sv
// Binary field to two decimal digits; values above 99 flag overflow.
module seg_bin2dec #(
    parameter int unsigned FIELD_W = 6
) (
    input  logic [FIELD_W-1:0] value,
    output logic [3:0]         tens,
    output logic [3:0]         ones,
    output logic               ovf
);

    int unsigned v;
    assign v = 32'(value);

    // Divide/modulo by a constant; digits forced to 0 on overflow.
    always_comb begin
        ovf  = (v > 32'd99);
        tens = '0;
        ones = '0;
        if (!ovf) begin
            tens = 4'(v / 32'd10);
            ones = 4'(v % 32'd10);
        end
    end

endmodule

// File: rtl/segment_scan.sv
// Multiplexed 7-segment scanner: blank/show slots per digit, per-frame snapshot.
// Optional blink feature is compiled in with SEGMENT_SCAN_BLINK_EN.
module segment_scan
    import seg_pkg::*;
#(
    parameter int unsigned N_FIELDS     = 2,
    parameter int unsigned FIELD_W      = 6,
    parameter int unsigned DIV          = 1000,
    parameter int unsigned SHOW_TICKS   = 3,
    parameter int unsigned ACTIVE_LOW   = 0,
`ifdef SEGMENT_SCAN_BLINK_EN
    parameter int unsigned BLINK_FRAMES = 32,
`endif
    parameter int unsigned LZS          = 0
) (
    input logic           clock,
    input logic           reset,
    segment_scan_if.slave bus
);

    localparam int unsigned N_DIGITS = 2 * N_FIELDS;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DW = $clog2(N_DIGITS);
    localparam int unsigned TW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam logic        INV = (ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

    logic [PW-1:0]               presc_q, presc_d;
    logic [DW-1:0]               digit_q, digit_d;
    logic [TW-1:0]               tcnt_q, tcnt_d;
    state_e                      state_q, state_d;
    logic [N_FIELDS*FIELD_W-1:0] shadow_q, shadow_d;
    logic                        frame_start_q, frame_start_d;
    logic [N_DIGITS-1:0]         bytee_q, bytee_d;
    logic [6:0]                  seg_q, seg_d;

    logic               tick;
    logic [FIELD_W-1:0] field_val;
    logic               blink_hit;
    logic [3:0]         tens, ones;
    logic               ovf;

    assign tick = (presc_q == PW'(DIV - 1));

    // Prescaler, slot FSM, digit pointer and snapshot; everything holds while disabled.
    always_comb begin
        presc_d       = presc_q;
        digit_d       = digit_q;
        tcnt_d        = tcnt_q;
        state_d       = state_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;
        if (bus.enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                unique case (state_q)
                    BLANK: begin
                        state_d = SHOW;
                        tcnt_d  = '0;
                        if (digit_q == '0) begin
                            shadow_d      = bus.data_show;
                            frame_start_d = 1'b1;
                        end
                    end
                    SHOW: begin
                        if (tcnt_q == TW'(SHOW_TICKS - 1)) begin
                            tcnt_d  = '0;
                            state_d = BLANK;
                            digit_d = (digit_q == DW'(N_DIGITS - 1)) ? '0 : digit_q + DW'(1);
                        end else begin
                            tcnt_d = tcnt_q + TW'(1);
                        end
                    end
                    default: state_d = BLANK;
                endcase
            end
        end
    end

    // Pick the shadow field (and its blink mask bit) that owns the current digit.
    always_comb begin
        field_val = '0;
        blink_hit = 1'b0;
        for (int k = 0; k < int'(N_FIELDS); k++) begin
            if (int'(digit_q >> 1) == k) begin
                field_val = shadow_q[k*FIELD_W +: FIELD_W];
`ifdef SEGMENT_SCAN_BLINK_EN
                blink_hit = bus.blink_mask[k];
`endif
            end
        end
    end

    seg_bin2dec #(
        .FIELD_W (FIELD_W)
    ) u_bin2dec (
        .value (field_val),
        .tens  (tens),
        .ones  (ones),
        .ovf   (ovf)
    );

`ifdef SEGMENT_SCAN_BLINK_EN
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    // Phase toggles after every BLINK_FRAMES frame_start pulses.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_start_q) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Blink phase registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    logic phase_q;
    assign phase_q = 1'b0;
`endif

    // Output stage decode; registered below, so outputs trail the FSM by one clock.
    always_comb begin
        bytee_d = '0;
        seg_d   = SEG_OFF;
        if (bus.enable && state_q == SHOW) begin
            bytee_d = ONE_HOT0 << digit_q;
            if (ovf) begin
                seg_d = SEG_DASH;
            end else if (digit_q[0]) begin
                seg_d = seg_of(tens);
            end else begin
                seg_d = seg_of(ones);
            end
            // Suppressed tens digit keeps its slot time, only the enable is dropped.
            if (LZS != 0 && digit_q[0] && tens == 4'd0 && !ovf) begin
                bytee_d = '0;
            end
            if (phase_q && blink_hit) begin
                bytee_d = '0;
            end
        end
    end

    // State and output registers; reset wins over enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q       <= '0;
            digit_q       <= '0;
            tcnt_q        <= '0;
            state_q       <= BLANK;
            shadow_q      <= '0;
            frame_start_q <= 1'b0;
            bytee_q       <= '0;
            seg_q         <= SEG_OFF;
        end else begin
            presc_q       <= presc_d;
            digit_q       <= digit_d;
            tcnt_q        <= tcnt_d;
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            frame_start_q <= frame_start_d;
            bytee_q       <= bytee_d;
            seg_q         <= seg_d;
        end
    end

    // Polarity inversion last, so the reset values are inverted as well.
    assign bus.bytee       = bytee_q ^ {N_DIGITS{INV}};
    assign bus.segment     = seg_q ^ {7{INV}};
    assign bus.frame_start = frame_start_q;

endmodule
